// File: rtl/demux2_stream.sv
// 1-to-2 packet stream demultiplexer. The lane is chosen from i_sel on the first beat and held until i_last.
// Optional per-lane beat counters are compiled in only when DEMUX2_STREAM_CNT_EN is defined.
module demux2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic             i_sel,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data0,
  output logic [WIDTH-1:0] o_data1,
  output logic             o_valid0,
  output logic             o_valid1,
  output logic             o_last0,
  output logic             o_last1,
  input  logic             i_ready0,
  input  logic             i_ready1,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_cnt0,
  output logic [CNT_W-1:0] o_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic tgt;
  logic tgt_busy;
  logic accept;
  logic load0;
  logic load1;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    tgt       = i_sel;

    unique case (state)
      IDLE:    tgt = i_sel;
      LOCK0:   tgt = 1'b0;
      LOCK1:   tgt = 1'b1;
      default: tgt = i_sel;
    endcase

    // A lane can take a beat if its register is empty or drains this same cycle.
    tgt_busy = tgt ? (o_valid1 & ~i_ready1) : (o_valid0 & ~i_ready0);
    o_ready  = i_rst_n & ~tgt_busy;
    accept   = i_valid & o_ready;
    load0    = accept & ~tgt;
    load1    = accept & tgt;

    if (accept) begin
      if (i_last) state_nxt = IDLE;
      else        state_nxt = tgt ? LOCK1 : LOCK0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid0 <= 1'b0;
      o_data0  <= '0;
      o_last0  <= 1'b0;
    end else if (load0) begin
      o_valid0 <= 1'b1;
      o_data0  <= i_data;
      o_last0  <= i_last;
    end else if (i_ready0) begin
      o_valid0 <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid1 <= 1'b0;
      o_data1  <= '0;
      o_last1  <= 1'b0;
    end else if (load1) begin
      o_valid1 <= 1'b1;
      o_data1  <= i_data;
      o_last1  <= i_last;
    end else if (i_ready1) begin
      o_valid1 <= 1'b0;
    end
  end

`ifdef DEMUX2_STREAM_CNT_EN
  // A clear that coincides with an accept counts that beat, so the lane restarts at 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt0 <= '0;
      o_cnt1 <= '0;
    end else if (i_cnt_clr) begin
      o_cnt0 <= load0 ? CNT_W'(1) : '0;
      o_cnt1 <= load1 ? CNT_W'(1) : '0;
    end else begin
      if (load0) o_cnt0 <= o_cnt0 + CNT_W'(1);
      if (load1) o_cnt1 <= o_cnt1 + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_cnt_clr;
  assign o_cnt0 = '0;
  assign o_cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench for demux2_stream: stimulus pushes expected lane beats, a negedge monitor pops and compares.
module tb_demux2_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] data;
  logic             valid, last, sel, rdy0, rdy1, cnt_clr;
  logic             o_ready, o_valid0, o_valid1, o_last0, o_last1;
  logic [WIDTH-1:0] o_data0, o_data1;
  logic [CNT_W-1:0] o_cnt0, o_cnt1;

  beat_t q0[$];
  beat_t q1[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_last(last),
    .i_sel(sel), .o_ready(o_ready), .o_data0(o_data0), .o_data1(o_data1),
    .o_valid0(o_valid0), .o_valid1(o_valid1), .o_last0(o_last0), .o_last1(o_last1),
    .i_ready0(rdy0), .i_ready1(rdy1), .i_cnt_clr(cnt_clr), .o_cnt0(o_cnt0), .o_cnt1(o_cnt1)
  );

`ifdef DEMUX2_STREAM_CNT_EN
  logic             w_ready, w_valid0, w_valid1, w_last0, w_last1;
  logic [WIDTH-1:0] w_data0, w_data1;
  logic [3:0]       w_cnt0, w_cnt1;

  demux2_stream #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_last(last),
    .i_sel(sel), .o_ready(w_ready), .o_data0(w_data0), .o_data1(w_data1),
    .o_valid0(w_valid0), .o_valid1(w_valid1), .o_last0(w_last0), .o_last1(w_last1),
    .i_ready0(rdy0), .i_ready1(rdy1), .i_cnt_clr(cnt_clr), .o_cnt0(w_cnt0), .o_cnt1(w_cnt1)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one beat that the bench expects to be accepted into lane exp_lane.
  task automatic send(input logic [WIDTH-1:0] d, input logic s, input logic l, input logic exp_lane);
    beat_t b;
    data  = d;
    sel   = s;
    last  = l;
    valid = 1'b1;
    b.d = d;
    b.l = l;
    if (exp_lane) q1.push_back(b);
    else          q0.push_back(b);
    @(negedge clk);
    check("send_ready", o_ready, 1);
    cyc();
    valid = 1'b0;
  endtask

  // Monitor: every delivered lane beat must match the head of that lane's queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (o_valid0 && rdy0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL lane0_extra: got 0x%0h expected no beat", o_data0);
        end else begin
          e = q0.pop_front();
          check("lane0_data", o_data0, e.d);
          check("lane0_last", o_last0, e.l);
        end
      end
      if (o_valid1 && rdy1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL lane1_extra: got 0x%0h expected no beat", o_data1);
        end else begin
          e = q1.pop_front();
          check("lane1_data", o_data1, e.d);
          check("lane1_last", o_last1, e.l);
        end
      end
    end
  end

  initial begin
    beat_t b;
    rst_n = 1'b0; data = '0; valid = 1'b0; last = 1'b0; sel = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0; cnt_clr = 1'b0;
    #1;
    check("rst_ready",  o_ready,  0);
    check("rst_valid0", o_valid0, 0);
    check("rst_valid1", o_valid1, 0);
    check("rst_data0",  o_data0,  0);
    check("rst_last1",  o_last1,  0);
    check("rst_cnt0",   o_cnt0,   0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy0 = 1'b1;
    rdy1 = 1'b1;

    // Single-beat packet to lane 1.
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    check("sb_valid1", o_valid1, 1);
    check("sb_data1",  o_data1,  8'hA5);
    check("sb_last1",  o_last1,  1);
    check("sb_valid0", o_valid0, 0);

    // Locked 3-beat packet: i_sel toggles after the first beat but all beats stay on lane 0.
    send(8'h11, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b1, 1'b0);
    check("lock_valid1", o_valid1, 0);
    cyc();

    // Backpressure on lane 0.
    rdy0 = 1'b0;
    send(8'h44, 1'b0, 1'b1, 1'b0);
    data = 8'h55; sel = 1'b0; last = 1'b1; valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_ready", o_ready, 0);
      cyc();
      check("bp_data0",  o_data0,  8'h44);
      check("bp_valid0", o_valid0, 1);
    end
    rdy0 = 1'b1;
    b.d = 8'h55; b.l = 1'b1;
    q0.push_back(b);
    @(negedge clk);
    check("bp_release_ready", o_ready, 1);
    cyc();
    valid = 1'b0;
    check("bp_nobubble_valid", o_valid0, 1);
    check("bp_nobubble_data",  o_data0,  8'h55);
    cyc();

    // Lane 0 stalled; a lane-1 packet still flows.
    rdy0 = 1'b0;
    send(8'h66, 1'b0, 1'b1, 1'b0);
    send(8'h77, 1'b1, 1'b1, 1'b1);
    send(8'h78, 1'b1, 1'b0, 1'b1);
    send(8'h79, 1'b0, 1'b1, 1'b1);
    check("nb_hold_valid0", o_valid0, 1);
    check("nb_hold_data0",  o_data0,  8'h66);
    rdy0 = 1'b1;
    cyc();
    cyc();

`ifdef DEMUX2_STREAM_CNT_EN
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check("cnt_clr0", o_cnt0, 0);
    check("cnt_clr1", o_cnt1, 0);
    for (int i = 0; i < 5; i++) send(8'hB0 + 8'(i), 1'b1, 1'b1, 1'b1);
    check("cnt1_five", o_cnt1, 5);
    check("cnt0_zero", o_cnt0, 0);
    cnt_clr = 1'b1;
    send(8'hB5, 1'b1, 1'b1, 1'b1);
    cnt_clr = 1'b0;
    check("cnt1_clr_accept", o_cnt1, 1);
    check("cnt0_clr_other",  o_cnt0, 0);
    for (int i = 0; i < 15; i++) send(8'hC0 + 8'(i), 1'b0, 1'b1, 1'b0);
    check("cnt4_fifteen", w_cnt0, 15);
    send(8'hCF, 1'b0, 1'b1, 1'b0);
    check("cnt4_wrap",   w_cnt0, 0);
    check("cnt16_count", o_cnt0, 16);
    cyc();
`else
    cnt_clr = 1'b1;
    send(8'hB5, 1'b1, 1'b1, 1'b1);
    cnt_clr = 1'b0;
    check("nocnt0", o_cnt0, 0);
    check("nocnt1", o_cnt1, 0);
    cyc();
`endif

    // Reset in the middle of a lane-1 packet with its first beat still held.
    rdy1 = 1'b0;
    send(8'h81, 1'b1, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid0", o_valid0, 0);
    check("mid_rst_valid1", o_valid1, 0);
    check("mid_rst_ready",  o_ready,  0);
    q1.delete();
    cyc();
    rst_n = 1'b1;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    send(8'h90, 1'b0, 1'b1, 1'b0);
    check("post_rst_valid0", o_valid0, 1);
    check("post_rst_data0",  o_data0,  8'h90);
    check("post_rst_valid1", o_valid1, 0);

    repeat (3) cyc();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of the routed stream.
REQ-002 SHALL have parameter CNT_W, default 16: width of each per-lane beat counter.
REQ-003 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_data  input  WIDTH  input beat data.
REQ-006 SHALL have port i_valid  input  1  input beat valid.
REQ-007 SHALL have port i_last  input  1  final beat of the packet.
REQ-008 SHALL have port i_sel  input  1  lane select (0 = lane 0, 1 = lane 1), sampled on the first beat of a packet only.
REQ-009 SHALL have port o_ready  output  1  input beat accepted when i_valid and o_ready are both 1.
REQ-010 SHALL have ports o_data0/o_data1  output  WIDTH  lane output data.
REQ-011 SHALL have ports o_valid0/o_valid1  output  1  lane output valid.
REQ-012 SHALL have ports o_last0/o_last1  output  1  lane output last.
REQ-013 SHALL have ports i_ready0/i_ready1  input  1  lane downstream ready.
REQ-014 SHALL have port i_cnt_clr  input  1  synchronous clear of both beat counters.
REQ-015 SHALL have ports o_cnt0/o_cnt1  output  CNT_W  beats delivered into each lane.

Function
REQ-016 SHALL hold one output register per lane (data, last, valid); latency from input accept to o_validN SHALL be exactly 1 cycle.
REQ-017 SHALL implement FSM states IDLE, LOCK0, LOCK1; target lane = i_sel in IDLE, 0 in LOCK0, 1 in LOCK1.
REQ-018 SHALL transition from IDLE to LOCKn on an accepted non-last beat routed to lane n; an accepted beat with i_last=1 SHALL leave or keep the FSM in IDLE.
REQ-019 SHALL ignore i_sel in LOCK0/LOCK1; accepted beat with i_last=1 SHALL return to IDLE.
REQ-020 SHALL drive o_ready = (target lane register empty) OR (target lane i_readyN=1); o_ready SHALL depend combinationally on i_sel in IDLE only.
REQ-021 SHALL load an accepted beat into the target lane register only; the other lane register SHALL be unchanged.
REQ-022 SHALL clear o_validN when i_readyN=1 and no new beat loads into lane N the same cycle; simultaneous drain and load SHALL keep o_validN=1 with the new beat, no bubble.
REQ-023 SHALL hold o_dataN/o_lastN stable while o_validN=1 and i_readyN=0.
REQ-024 SHALL allow the idle lane to drain while the other lane accepts new beats (no head-of-line blocking across lanes).
REQ-025 SHALL increment o_cntN by 1 per beat accepted into lane N, wrapping from 2^CNT_W-1 to 0.
REQ-026 SHALL, on i_cnt_clr=1 coincident with an accept to lane N, set o_cntN to 1; the other counter SHALL become 0.

Reset
REQ-027 SHALL, on i_rst_n=0 asynchronously, set FSM to IDLE, o_valid0/o_valid1=0, o_last0/o_last1=0, o_data0/o_data1=0, o_cnt0/o_cnt1=0.
REQ-028 SHALL drive o_ready=0 while i_rst_n=0; reset mid-packet SHALL discard the locked lane and held beats, first beat after release samples i_sel.

Configuration
REQ-029 SHALL compile beat counters only when macro DEMUX2_STREAM_CNT_EN is defined; without it, o_cnt0/o_cnt1 SHALL be constant 0, i_cnt_clr ignored, no counter flops present, all other behaviour identical.

Verification
REQ-030 SHALL cover single-beat packet: i_sel=1, i_last=1, data 0xA5, i_ready1=1 -> o_valid1=1 with 0xA5, o_last1=1 next cycle, o_valid0 stays 0, FSM IDLE.
REQ-031 SHALL cover lock: 3-beat packet 0x11,0x22,0x33 starting i_sel=0, i_sel toggled on beats 2-3 -> all three beats on lane 0, o_last0=1 only on 0x33.
REQ-032 SHALL cover backpressure: lane 0 holding beat, i_ready0=0, next beat to lane 0 -> o_ready=0, o_data0 stable; i_ready0=1 -> accept, no bubble.
REQ-033 SHALL cover non-blocking: lane 0 stalled with beat held, new packet i_sel=1 -> o_ready=1, beat delivered on lane 1.
REQ-034 SHALL cover counters (macro defined): 5 beats to lane 1, then i_cnt_clr with lane-1 accept -> o_cnt1=5 then 1; CNT_W=4 after 16 beats -> o_cnt0 wraps to 0.
REQ-035 SHALL cover reset mid-packet: i_rst_n=0 after beat 1 of LOCK1 packet -> all valids 0 immediately; after release i_sel=0 beat routes to lane 0.
